down_cnt_ctrl: RTL and testbench

//  Iteration sequencer for the factorial datapath. Loads an operand N on start,

---
 rtl/down_cnt_pkg.sv | 13 +
 rtl/dcnt_reg.sv | 44 ++++
 rtl/down_cnt_ctrl.sv | 112 +++++++++++
 tb/tb_down_cnt_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/down_cnt_pkg.sv
// Shared definitions for the down-counting iteration sequencer:
// FSM state encodings and the default operand width.
package down_cnt_pkg;

    localparam int DCNT_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dcnt_st_e;

endpackage

// File: rtl/dcnt_reg.sv
// Loadable down-count register with a saturating decrement
// and a terminal flag that marks the last step (q == 1).
module dcnt_reg
    import down_cnt_pkg::*;
#(
    parameter int SIZE = DCNT_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            ld_i,
    input  logic [SIZE-1:0] ld_val_i,
    input  logic            dec_i,
    output logic [SIZE-1:0] q_o,
    output logic            term_o
);

    logic [SIZE-1:0] q_q;
    logic [SIZE-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = ld_val_i;
        end else if (dec_i && (q_q != '0)) begin
            // Guarded so the count can never wrap below zero.
            q_d = q_q - SIZE'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign term_o = (q_q == SIZE'(1));

endmodule

// File: rtl/down_cnt_ctrl.sv
// Iteration sequencer: presents N, N-1, ..., 1 over a valid/ready handshake.
// Optional DOWN_CNT_ABORT_EN adds an abort input that returns to IDLE.
module down_cnt_ctrl
    import down_cnt_pkg::*;
#(
    parameter int SIZE = DCNT_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] d,
`ifdef DOWN_CNT_ABORT_EN
    input  logic            abort,
`endif
    output logic [SIZE-1:0] q,
    output logic            step_valid,
    input  logic            step_ready,
    output logic            busy,
    output logic            done,
    output logic            zero_op
);

    dcnt_st_e state_q;
    dcnt_st_e state_d;
    logic     zero_q;
    logic     zero_d;
    logic     ld;
    logic     dec;
    logic     clr;
    logic     term;
    logic     xfer;
    logic     abort_w;

`ifdef DOWN_CNT_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign xfer = step_valid & step_ready;

    dcnt_reg #(
        .SIZE(SIZE)
    ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .ld_i    (ld),
        .ld_val_i(d),
        .dec_i   (dec),
        .q_o     (q),
        .term_o  (term)
    );

    always_comb begin
        state_d = state_q;
        zero_d  = zero_q;
        ld      = 1'b0;
        dec     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ld = 1'b1;
                    if (d == '0) begin
                        state_d = ST_DONE;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a transfer in the same cycle.
                if (abort_w) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else if (xfer) begin
                    dec = 1'b1;
                    if (term) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                zero_d  = 1'b0;
                clr     = abort_w;
            end
            default: begin
                state_d = ST_IDLE;
                zero_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zero_q  <= zero_d;
        end
    end

    assign step_valid = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE) & ~abort_w;
    assign zero_op    = zero_q & done;

endmodule

// File: tb/tb_down_cnt_ctrl.sv
// Scoreboard bench for down_cnt_ctrl: random operands and ready patterns
// checked against a queue-based model of the N..1 sequence.
module tb_down_cnt_ctrl;

    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] d = '0;
    logic [SIZE-1:0] q;
    logic            step_valid;
    logic            step_ready = 1'b0;
    logic            busy;
    logic            done;
    logic            zero_op;
`ifdef DOWN_CNT_ABORT_EN
    logic            abort = 1'b0;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    int exp_q[$];
    bit exp_zero[$];

    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic [SIZE-1:0] prev_q = '0;
    int              n_xfer = 0;

    always #5 clk = ~clk;

    down_cnt_ctrl #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d         (d),
`ifdef DOWN_CNT_ABORT_EN
        .abort     (abort),
`endif
        .q         (q),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .busy      (busy),
        .done      (done),
        .zero_op   (zero_op)
    );

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor: every presented step and every done pulse is
    // matched against what the stimulus side predicted.
    always @(negedge clk) begin
        if (!rst) begin
            if (step_valid) begin
                chk("busy_in_run", int'(busy), 1);
                if (prev_valid && !prev_ready)
                    chk("q_stable_stall", int'(q), int'(prev_q));
                if (step_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_step", int'(q), -1);
                    end else begin
                        chk("step_q", int'(q), exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                if (exp_zero.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("zero_op", int'(zero_op), int'(exp_zero.pop_front()));
                    chk("steps_left_at_done", exp_q.size(), 0);
                end
            end else if (zero_op) begin
                chk("zero_op_without_done", 1, 0);
            end
        end
        prev_valid = step_valid;
        prev_ready = step_ready;
        prev_q     = q;
    end

    task automatic push_model(input int n);
        for (int v = n; v >= 1; v--) exp_q.push_back(v);
        exp_zero.push_back(n == 0);
    endtask

    // mode 0: ready held high; 1: random ready; 2: pattern 1,0,0,1,1...
    task automatic run_seq(input int n, input int mode, input bit poke);
        int c;
        int x0;
        bit seen;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(posedge clk); #1;
        start = 1'b1;
        d = SIZE'(n);
        push_model(n);
        x0 = n_xfer;
        seen = 1'b0;
        for (c = 1; c <= 3000; c++) begin
            @(posedge clk); #1;
            start = poke && (c == 2);
            d = poke && (c == 2) ? SIZE'(9) : SIZE'($urandom);
            case (mode)
                0: step_ready = 1'b1;
                1: step_ready = 1'($urandom_range(0, 1));
                default: step_ready = (c <= 5) ? pat[c-1] : 1'b1;
            endcase
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
        if (mode == 0) chk("done_latency", c, n + 1);
        chk("xfer_count", n_xfer - x0, n);
        @(posedge clk); #1;
        start = 1'b0;
        step_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_done", int'({busy, done, step_valid}), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_flags", int'({step_valid, busy, done, zero_op}), 0);
        rst = 1'b0;

        // Reset asserted in the middle of a sequence.
        @(posedge clk); #1;
        start = 1'b1; d = 8'd5; step_ready = 1'b1;
        push_model(5);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_zero.delete();
        #1;
        chk("midrst_q", int'(q), 0);
        chk("midrst_flags", int'({step_valid, busy, done, zero_op}), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        step_ready = 1'b0;
        run_seq(3, 0, 1'b0);

        run_seq(4, 0, 1'b0);
        run_seq(0, 0, 1'b0);
        run_seq(3, 2, 1'b0);
        run_seq(6, 0, 1'b1);
        run_seq(255, 0, 1'b0);
        run_seq(1, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_seq(int'($urandom_range(0, 12)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef DOWN_CNT_ABORT_EN
        @(posedge clk); #1;
        start = 1'b1; d = 8'd4; step_ready = 1'b0;
        push_model(4);
        @(posedge clk); #1;
        start = 1'b0; step_ready = 1'b1;
        @(posedge clk); #1;
        step_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_pre_q", int'(q), 2);
        abort = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_zero.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        step_ready = 1'b0;
        chk("abort_q", int'(q), 0);
        chk("abort_flags", int'({step_valid, busy, done}), 0);
        repeat (2) @(negedge clk);
        run_seq(2, 0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        chk("queue_empty_end", exp_q.size() + exp_zero.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
